// File: rtl/mips_pipe_pkg.sv
// Shared widths, constants and helpers for the MIPS-style pipeline.
// Used by id_ex_stage and hazard_unit.
package mips_pipe_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int CTRL_W = 6;

    localparam logic [3:0] ZERO_REG      = 4'd0;
    localparam logic [7:0] STALL_CNT_MAX = 8'd255;

    // Layout of the pass-through control bundle
    localparam int CTRL_ALU_LSB   = 0;
    localparam int CTRL_ALU_W     = 4;
    localparam int CTRL_MEM_WRITE = 4;
    localparam int CTRL_BRANCH    = 5;

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == STALL_CNT_MAX) ? c : c + 8'd1;
    endfunction

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detect between the load in EX and the instruction in ID.
// Purely combinational.
module hazard_unit #(
    parameter int ADDR_W = mips_pipe_pkg::ADDR_W
) (
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_reg_write,
    input  logic [ADDR_W-1:0] ex_caddr,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_aaddr,
    input  logic [ADDR_W-1:0] id_baddr,
    output logic              hazard
);
    import mips_pipe_pkg::*;

    logic ld_live;
    logic dep;

    assign ld_live = ex_valid & ex_mem_read & ex_reg_write
                   & (ex_caddr != ADDR_W'(ZERO_REG));
    assign dep     = (ex_caddr == id_aaddr) | (ex_caddr == id_baddr);
    assign hazard  = ld_live & id_valid & dep;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush and stall counter.
// Define FWD_WB_EN to bypass the writeback value into the A/B operands.
module id_ex_stage #(
    parameter int DATA_W = mips_pipe_pkg::DATA_W,
    parameter int ADDR_W = mips_pipe_pkg::ADDR_W,
    parameter int CTRL_W = mips_pipe_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_stall,
    input  logic [ADDR_W-1:0] id_aaddr,
    input  logic [ADDR_W-1:0] id_baddr,
    input  logic [ADDR_W-1:0] id_caddr,
    input  logic [DATA_W-1:0] id_a,
    input  logic [DATA_W-1:0] id_b,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    input  logic              wb_load,
    input  logic [ADDR_W-1:0] wb_caddr,
    input  logic [DATA_W-1:0] wb_c,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [ADDR_W-1:0] ex_aaddr,
    output logic [ADDR_W-1:0] ex_baddr,
    output logic [ADDR_W-1:0] ex_caddr,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [7:0]        stall_count
);
    import mips_pipe_pkg::*;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] imm;
        logic [ADDR_W-1:0] aaddr;
        logic [ADDR_W-1:0] baddr;
        logic [ADDR_W-1:0] caddr;
        logic              reg_write;
        logic              mem_read;
        logic [CTRL_W-1:0] ctrl;
    } id_ex_t;

    id_ex_t            ex_q;
    id_ex_t            ex_d;
    logic              hazard;
    logic [DATA_W-1:0] a_src;
    logic [DATA_W-1:0] b_src;

`ifdef FWD_WB_EN
    logic wb_hit;
    logic fwd_a;
    logic fwd_b;

    assign wb_hit = wb_load & (wb_caddr != ADDR_W'(ZERO_REG));
    assign fwd_a  = wb_hit & (wb_caddr == id_aaddr);
    assign fwd_b  = wb_hit & (wb_caddr == id_baddr);
    assign a_src  = fwd_a ? wb_c : id_a;
    assign b_src  = fwd_b ? wb_c : id_b;
`else
    logic unused_wb;

    assign unused_wb = ^{wb_load, wb_caddr, wb_c};
    assign a_src     = id_a;
    assign b_src     = id_b;
`endif

    hazard_unit #(
        .ADDR_W (ADDR_W)
    ) u_hazard (
        .ex_valid     (ex_q.valid),
        .ex_mem_read  (ex_q.mem_read),
        .ex_reg_write (ex_q.reg_write),
        .ex_caddr     (ex_q.caddr),
        .id_valid     (id_valid),
        .id_aaddr     (id_aaddr),
        .id_baddr     (id_baddr),
        .hazard       (hazard)
    );

    assign id_stall = hazard & ~flush & rst_n;

    always_comb begin
        ex_d = '0;
        priority case (1'b1)
            flush:    ex_d = '0;
            hazard:   ex_d = '0;
            id_valid: begin
                ex_d.valid     = 1'b1;
                ex_d.a         = (id_aaddr == ADDR_W'(ZERO_REG)) ? '0 : a_src;
                ex_d.b         = (id_baddr == ADDR_W'(ZERO_REG)) ? '0 : b_src;
                ex_d.imm       = id_imm;
                ex_d.aaddr     = id_aaddr;
                ex_d.baddr     = id_baddr;
                ex_d.caddr     = id_caddr;
                ex_d.reg_write = id_reg_write;
                ex_d.mem_read  = id_mem_read;
                ex_d.ctrl      = id_ctrl;
            end
            default:  ex_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q        <= '0;
            stall_count <= '0;
        end else begin
            ex_q <= ex_d;
            if (hazard & ~flush)
                stall_count <= sat_inc(stall_count);
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_a         = ex_q.a;
    assign ex_b         = ex_q.b;
    assign ex_imm       = ex_q.imm;
    assign ex_aaddr     = ex_q.aaddr;
    assign ex_baddr     = ex_q.baddr;
    assign ex_caddr     = ex_q.caddr;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_ctrl      = ex_q.ctrl;

endmodule
